cim_result_writeback: RTL
=========================

# cim_result_writeback

Drains the CIM macro's output registers into data RAM once a GeMM tile finishes, without per-word CPU load/store traffic. It sits directly downstream of the CIM macro: it selects each output register through `output_reg` and reads `cim_output`. It optionally shifts and ReLU-clips each value, then writes it to RAM through a granted write port shared with the CPU. It can also pulse `reset_output` to clear the accumulators for the next tile.

## Interface
- `NREG`, default 16: number of CIM output registers; the index width is 4.
- `CLK` in 1: clock, rising-edge.
- `RES` in 1: reset, asynchronous, active-high.
- `start` in 1: drain request; sampled only in IDLE.
- `base_addr` in 32: byte address of the first word; word-aligned.
- `num_regs` in 5: words to drain; values above 16 clamp to 16; 0 means no-op.
- `addr_stride` in 16: unsigned byte increment between words.
- `shift` in 5: arithmetic right-shift amount applied to each word.
- `relu_en` in 1: clamp negative results to 0.
- `clear_after` in 1: pulse `reset_output` after the last write.
- `cim_output` in 32: selected CIM register value, valid 1 cycle after `output_reg` changes.
- `mem_grant` in 1: the write port is granted this cycle.
- `busy` out 1: the engine is not in IDLE.
- `done` out 1: one-cycle completion pulse.
- `output_reg` out 4: CIM register select.
- `reset_output` out 1: one-cycle CIM accumulator clear.
- `mem_wr`, `mem_addr[31:0]`, `mem_data[31:0]`, `mem_be[3:0]` out: RAM write port.

## Operation
- Configuration inputs are latched on start acceptance; later changes have no effect.
- The FSM has six states: IDLE, SEL, CAP, WRITE, CLR, DONE.
- **IDLE**
  - `start`=1 with N>0 → SEL, with idx=0 and addr=`base_addr`.
  - `start`=1 with N=0 → DONE.
- **SEL**: drive `output_reg`=idx → CAP.
- **CAP**: latch `data = relu(cim_output >>> shift)` → WRITE.
  - The shift is signed and sign-extending.
  - relu outputs 0 when `relu_en`=1 and the shifted value is negative.
- **WRITE**: drive `mem_wr`=1, `mem_addr`=addr, `mem_data`=data, `mem_be`=4'hF.
  - The word is accepted in the cycle where `mem_grant`=1.
  - On acceptance: idx+1; addr+=stride, wrapping modulo 2^32.
  - After acceptance, go to SEL if idx<N−1; otherwise CLR if `clear_after`, else DONE.
  - While `mem_grant`=0, stay in WRITE with all `mem_*` outputs held stable.
- **CLR**: `reset_output`=1 for exactly one cycle → DONE.
- **DONE**: `done`=1 → IDLE.
- `busy` = (state ≠ IDLE).
- `start` while busy is ignored and is not queued.
- `output_reg` holds its last value outside SEL/CAP.
- `mem_wr` is 0 outside WRITE.
- `mem_addr`/`mem_data` may hold stale values when `mem_wr`=0.

## Timing
- **Reset**: all outputs are 0 (`busy`, `done`, `output_reg`, `reset_output`, `mem_wr`, `mem_addr`, `mem_data`, `mem_be`); state is IDLE.
- Reset asserted mid-drain aborts immediately:
  - No `done` pulse and no `reset_output` pulse.
  - A partially drained tile is left as-is.
  - The first `start` after `RES` deasserts is accepted normally.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Cycle accounting, with `start` sampled at edge 0:
  - SEL occupies cycle 1, CAP cycle 2, WRITE cycle 3.
  - With `mem_grant` held at 1, word k is written in cycle 3k+3.
  - `done` is high in cycle 3N+1, or 3N+2 when `clear_after`=1.
  - `reset_output` is high in cycle 3N+1 when `clear_after`=1.
- Each grant-low cycle in WRITE adds exactly 1 cycle.
- N=0: `done` in cycle 1, with no `mem_wr` and no `reset_output`.
- `busy` rises the cycle after acceptance and falls the cycle after DONE.
- A new `start` is accepted at the earliest in the cycle after `busy` falls.
- Throughput is 1 word per 3 cycles.

## Test plan
- **Basic drain**
  - Setup: CIM regs 0..3 = 10, −20, 30, −40; base=43776, stride=4, N=4, shift=0, relu=0, grant=1.
  - Required: writes of 10, 0xFFFFFFEC, 30, 0xFFFFFFD8 to 43776/43780/43784/43788; `done` at cycle 13; BE=F every write.
- **Shift + ReLU**
  - Setup: reg0 = −256, reg1 = 1024; shift=4, relu=1, N=2.
  - Required: writes 0 then 64.
- **Grant stall**
  - Setup: N=2, grant low for 5 cycles during the first WRITE.
  - Required: addr/data stable across the stall, exactly one write per word, `done` at cycle 12.
- **Clear + N=0**
  - Setup: `clear_after`=1 with N=16, stride=784, base=0.
  - Required: last write to 11760 at cycle 48, `reset_output` pulse at cycle 49, `done` at cycle 50.
  - Then: `start` with N=0 → `done` at cycle 1, no writes.
- **Clamp + reject**
  - Setup: `num_regs`=20.
  - Required: exactly 16 writes; a `start` pulse while busy produces no second drain.
- **Async reset**
  - Setup: assert `RES` during the CAP of word 2.
  - Required: all outputs 0 immediately, no `done`; next `start` runs a full drain correctly.

Source files
------------

// File: rtl/cim_result_writeback.sv
// cim_result_writeback: drains CIM output registers into data RAM.
// Ports: CLK/RES, start+config in, cim_output/mem_grant in, busy/done/output_reg/reset_output/mem_* out.
module cim_result_writeback #(
  parameter int NREG = 16,
  localparam int IW = $clog2(NREG)
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          start,
  input  logic [31:0]   base_addr,
  input  logic [4:0]    num_regs,
  input  logic [15:0]   addr_stride,
  input  logic [4:0]    shift,
  input  logic          relu_en,
  input  logic          clear_after,
  input  logic [31:0]   cim_output,
  input  logic          mem_grant,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] output_reg,
  output logic          reset_output,
  output logic          mem_wr,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_data,
  output logic [3:0]    mem_be
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_CAP,
    S_WRITE,
    S_CLR,
    S_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [31:0]   addr;
  logic [4:0]    n_q;
  logic [15:0]   stride_q;
  logic [4:0]    shift_q;
  logic          relu_q;
  logic          clr_q;

  logic [4:0]    n_in;
  logic [IW-1:0] idx_inc;
  logic [4:0]    idx_ext;
  logic [31:0]   shv;
  logic [31:0]   data_c;

  // Requests beyond the register file size drain the whole file.
  assign n_in    = (num_regs > 5'(NREG)) ? 5'(NREG) : num_regs;
  assign idx_inc = idx + IW'(1);
  assign idx_ext = 5'(idx);

  always_comb begin
    shv    = 32'($signed(cim_output) >>> shift_q);
    data_c = (relu_q && shv[31]) ? 32'd0 : shv;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state        <= S_IDLE;
      idx          <= '0;
      addr         <= '0;
      n_q          <= '0;
      stride_q     <= '0;
      shift_q      <= '0;
      relu_q       <= 1'b0;
      clr_q        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      output_reg   <= '0;
      reset_output <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_be       <= '0;
    end else begin
      done         <= 1'b0;
      reset_output <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            n_q      <= n_in;
            stride_q <= addr_stride;
            shift_q  <= shift;
            relu_q   <= relu_en;
            clr_q    <= clear_after;
            busy     <= 1'b1;
            if (n_in != 5'd0) begin
              state      <= S_SEL;
              idx        <= '0;
              addr       <= base_addr;
              output_reg <= '0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        // output_reg was set on entry; the macro needs this cycle to settle.
        S_SEL: state <= S_CAP;
        S_CAP: begin
          mem_wr   <= 1'b1;
          mem_addr <= addr;
          mem_data <= data_c;
          mem_be   <= 4'hF;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          if (mem_grant) begin
            mem_wr <= 1'b0;
            idx    <= idx_inc;
            addr   <= addr + {16'd0, stride_q};
            if (idx_ext < n_q - 5'd1) begin
              state      <= S_SEL;
              output_reg <= idx_inc;
            end else if (clr_q) begin
              state        <= S_CLR;
              reset_output <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_CLR: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
